// File: rtl/fwd_scoreboard.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// A shadow pipeline mirrors in-flight producers; per source it picks register file, bypass or stall.
module fwd_scoreboard #(
  parameter int unsigned NUM_RS = 2,
  parameter int unsigned STAGES = 3,
  parameter int unsigned SW     = $clog2(STAGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NUM_RS*5-1:0]  id_rs_addr,
  input  logic [NUM_RS-1:0]    id_rs_used,
  input  logic [4:0]           id_rd_addr,
  input  logic                 id_reg_write,
  input  logic [SW-1:0]        id_ready_stage,
  input  logic                 flush,
  input  logic                 freeze,
  output logic                 stall_ID,
  output logic [NUM_RS*SW-1:0] fw_sel_EX,
  output logic [31:0]          stall_count
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] we_q;
  logic [4:0]        rd_q    [STAGES];
  logic [SW-1:0]     ready_q [STAGES];

  logic [NUM_RS*SW-1:0] sel_calc;
  logic                 hazard;
  logic                 found;
  logic [4:0]           rs;
  logic                 accept;
  logic [SW-1:0]        ready_norm;

  // Scan entries youngest-first; only the first match for each source decides its outcome.
  always_comb begin
    sel_calc = '0;
    hazard   = 1'b0;
    found    = 1'b0;
    rs       = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rs    = id_rs_addr[5*i +: 5];
      found = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (!found && valid_q[k] && we_q[k] && (rd_q[k] == rs) && (rs != 5'd0) &&
            id_rs_used[i] && id_valid) begin
          found = 1'b1;
          if (k == STAGES - 1) begin
            // Register file is write-through, so the WB result is visible via the normal read.
            sel_calc[SW*i +: SW] = '0;
          end else if (32'(ready_q[k]) <= k + 1) begin
            sel_calc[SW*i +: SW] = SW'(k + 1);
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign stall_ID   = id_valid & ~flush & hazard;
  assign accept     = id_valid & ~flush & ~stall_ID;
  assign ready_norm = (id_ready_stage == '0) ? SW'(1) : id_ready_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      we_q        <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        rd_q[k]    <= '0;
        ready_q[k] <= '0;
      end
      fw_sel_EX   <= '0;
      stall_count <= '0;
    end else if (!freeze) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        ready_q[k] <= ready_q[k-1];
      end
      valid_q[0] <= accept;
      we_q[0]    <= id_reg_write;
      rd_q[0]    <= id_rd_addr;
      ready_q[0] <= ready_norm;
      fw_sel_EX  <= accept ? sel_calc : '0;
      if (stall_ID && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed, table-driven bench for fwd_scoreboard (default config plus a NUM_RS=3/STAGES=5 instance).
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Default configuration: NUM_RS = 2, STAGES = 3, SW = 2
  logic        id_valid, id_reg_write, flush, freeze;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd_addr;
  logic [1:0]  id_ready_stage;
  logic        stall_id;
  logic [3:0]  fw_sel;
  logic [31:0] stall_count;

  fwd_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs_addr     (id_rs_addr),
    .id_rs_used     (id_rs_used),
    .id_rd_addr     (id_rd_addr),
    .id_reg_write   (id_reg_write),
    .id_ready_stage (id_ready_stage),
    .flush          (flush),
    .freeze         (freeze),
    .stall_ID       (stall_id),
    .fw_sel_EX      (fw_sel),
    .stall_count    (stall_count)
  );

  // Wide configuration: NUM_RS = 3, STAGES = 5, SW = 3
  logic        b_valid, b_reg_write, b_flush, b_freeze;
  logic [14:0] b_rs_addr;
  logic [2:0]  b_rs_used;
  logic [4:0]  b_rd_addr;
  logic [2:0]  b_ready_stage;
  logic        b_stall;
  logic [8:0]  b_sel;
  logic [31:0] b_count;

  fwd_scoreboard #(.NUM_RS(3), .STAGES(5)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (b_valid),
    .id_rs_addr     (b_rs_addr),
    .id_rs_used     (b_rs_used),
    .id_rd_addr     (b_rd_addr),
    .id_reg_write   (b_reg_write),
    .id_ready_stage (b_ready_stage),
    .flush          (b_flush),
    .freeze         (b_freeze),
    .stall_ID       (b_stall),
    .fw_sel_EX      (b_sel),
    .stall_count    (b_count)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs0, rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       we;
    logic [1:0] rdy;
    logic       fl, fz;
    int         e_stall, e_sel0, e_sel1, e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input int rs0, input int rs1, input int used,
                              input int rd, input logic we, input int rdy, input logic fl,
                              input logic fz, input int e_stall, input int e_sel0,
                              input int e_sel1, input int e_cnt);
    vec_t r;
    r.v = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used); r.rd = 5'(rd);
    r.we = we; r.rdy = 2'(rdy); r.fl = fl; r.fz = fz;
    r.e_stall = e_stall; r.e_sel0 = e_sel0; r.e_sel1 = e_sel1; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_reg_write = 0; flush = 0; freeze = 0;
    id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0; id_ready_stage = '0;
    b_valid = 0; b_reg_write = 0; b_flush = 0; b_freeze = 0;
    b_rs_addr = '0; b_rs_used = '0; b_rd_addr = '0; b_ready_stage = '0;

    //                v rs0 rs1 u  rd we r fl fz  st s0 s1 cnt
    tbl.push_back(mk(1,  1,  2, 3,  5, 1, 1, 0, 0, 0, 0, 0, 0)); // add x5
    tbl.push_back(mk(1,  5,  7, 3,  6, 1, 1, 0, 0, 0, 1, 0, 0)); // sub x6,x5,x7 -> MEM bypass
    tbl.push_back(mk(1,  1,  0, 1,  8, 1, 2, 0, 0, 0, 0, 0, 0)); // lw x8
    tbl.push_back(mk(1,  8,  6, 3,  9, 1, 1, 0, 0, 1, 0, 0, 1)); // load-use stall
    tbl.push_back(mk(1,  8,  6, 3,  9, 1, 1, 0, 0, 0, 2, 0, 1)); // x8 from WB bus, x6 at WB -> 0
    tbl.push_back(mk(1,  1,  2, 3,  5, 1, 1, 0, 0, 0, 0, 0, 1)); // add x5 (older)
    tbl.push_back(mk(1,  3,  4, 3,  5, 1, 1, 0, 0, 0, 0, 0, 1)); // add x5 (younger)
    tbl.push_back(mk(1,  5,  9, 3, 10, 1, 1, 0, 0, 0, 1, 0, 1)); // youngest wins
    tbl.push_back(mk(1,  3,  4, 3, 11, 1, 1, 0, 0, 0, 0, 0, 1)); // independent
    tbl.push_back(mk(1, 10,  0, 1, 12, 1, 1, 0, 0, 0, 2, 0, 1)); // one gap -> 2
    tbl.push_back(mk(1, 11, 10, 3,  0, 1, 2, 0, 0, 0, 2, 0, 1)); // two gaps -> 0; lw x0
    tbl.push_back(mk(1,  0, 12, 3, 13, 1, 1, 0, 0, 0, 0, 2, 1)); // x0 never matched
    tbl.push_back(mk(1, 13, 13, 1, 14, 1, 2, 0, 0, 0, 1, 0, 1)); // rs1 unused; lw x14
    tbl.push_back(mk(1, 14,  0, 1, 15, 1, 1, 0, 1, 1, 1, 0, 1)); // stall under freeze: hold
    tbl.push_back(mk(1, 14,  0, 1, 15, 1, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 14,  0, 1, 15, 1, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 14,  0, 1, 15, 1, 1, 0, 0, 1, 0, 0, 2)); // freeze drops: one stall
    tbl.push_back(mk(1, 14,  0, 1, 15, 1, 1, 0, 0, 0, 2, 0, 2));
    tbl.push_back(mk(1,  0,  0, 0, 16, 1, 2, 0, 0, 0, 0, 0, 2)); // lw x16
    tbl.push_back(mk(1, 16,  0, 1, 17, 1, 1, 1, 0, 0, 0, 0, 2)); // flush beats hazard
    tbl.push_back(mk(1, 16,  0, 1, 17, 1, 1, 0, 0, 0, 2, 0, 2));
    tbl.push_back(mk(1,  0,  0, 0, 18, 1, 0, 0, 0, 0, 0, 0, 2)); // ready 0 acts as 1
    tbl.push_back(mk(1, 18,  0, 1, 19, 1, 1, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 19,  0, 1, 20, 1, 1, 0, 0, 0, 0, 0, 2)); // invalid ID: no match
    tbl.push_back(mk(1, 19,  0, 1,  5, 1, 2, 0, 0, 0, 2, 0, 2)); // lw x5, bypass x19

    #1;
    chk("reset stall_ID", int'(stall_id), 0);
    chk("reset fw_sel_EX", int'(fw_sel), 0);
    chk("reset stall_count", int'(stall_count), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[n]) begin
      id_valid = tbl[n].v; id_rs_addr = {tbl[n].rs1, tbl[n].rs0}; id_rs_used = tbl[n].used;
      id_rd_addr = tbl[n].rd; id_reg_write = tbl[n].we; id_ready_stage = tbl[n].rdy;
      flush = tbl[n].fl; freeze = tbl[n].fz;
      #1;
      chk($sformatf("row%0d stall_ID", n), int'(stall_id), tbl[n].e_stall);
      @(posedge clk); #1;
      chk($sformatf("row%0d sel0", n), int'(fw_sel[1:0]), tbl[n].e_sel0);
      chk($sformatf("row%0d sel1", n), int'(fw_sel[3:2]), tbl[n].e_sel1);
      chk($sformatf("row%0d stall_count", n), int'(stall_count), tbl[n].e_cnt);
    end

    // Reset while lw x5 sits in EX and a user of x5 is in ID.
    id_valid = 1; id_rs_addr = {5'd0, 5'd5}; id_rs_used = 2'b01; id_rd_addr = 5'd20;
    id_reg_write = 1; id_ready_stage = 2'd1; flush = 0; freeze = 0;
    #1;
    chk("pre-reset load-use stall", int'(stall_id), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset fw_sel_EX", int'(fw_sel), 0);
    chk("async reset stall_count", int'(stall_count), 0);
    chk("async reset stall_ID", int'(stall_id), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post-reset stall_ID", int'(stall_id), 0);
    @(posedge clk); #1;
    chk("post-reset sel0", int'(fw_sel[1:0]), 0);
    chk("post-reset stall_count", int'(stall_count), 0);
    id_valid = 0;

    // Wide instance: ready=4 producer stalls a source-2 dependent for 3 cycles, then sel=4.
    b_valid = 1; b_rs_addr = '0; b_rs_used = '0; b_rd_addr = 5'd7;
    b_reg_write = 1; b_ready_stage = 3'd4;
    #1;
    chk("wide producer stall", int'(b_stall), 0);
    @(posedge clk); #1;
    b_rs_addr = {5'd7, 5'd7, 5'd7}; b_rs_used = 3'b100; b_rd_addr = 5'd9; b_ready_stage = 3'd1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("wide stall cycle %0d", c), int'(b_stall), 1);
      @(posedge clk); #1;
      chk($sformatf("wide count cycle %0d", c), int'(b_count), c);
      chk($sformatf("wide bubble sel cycle %0d", c), int'(b_sel), 0);
    end
    #1;
    chk("wide stall released", int'(b_stall), 0);
    @(posedge clk); #1;
    chk("wide sel2", int'(b_sel[8:6]), 4);
    chk("wide sel0", int'(b_sel[2:0]), 0);
    chk("wide final count", int'(b_count), 3);
    b_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
